fp_add_sub_arbiter: RTL and testbench

- Round-robin arbiter that shares one pipelined fp_add_sub instance between N requesters.
- Accepts independent add/sub requests and issues at most one per cycle into the adder.
- Tracks each in-flight operation's requester ID through a tag pipeline matched to the adder latency, and returns each result tagged with its ID.
- Converts the requesters' natural polarity (sub=1 means subtract) to the adder's opSel convention (opSel=1 ADD, opSel=0 SUB). Backpressure stalls the whole adder through its en input.

---
 rtl/fp_add_sub_arbiter.sv | 102 ++++++++++
 tb/tb_fp_add_sub_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sub_arbiter.sv
// Round-robin front end that shares one pipelined fp_add_sub between N requesters.
// Each issued op carries its requester ID down a tag pipeline aligned with the adder latency.
module fp_add_sub_arbiter #(
    parameter int N       = 4,
    parameter int LATENCY = 3,
    parameter int IDW     = 2
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [32*N-1:0]   req_a,
    input  logic [32*N-1:0]   req_b,
    input  logic [N-1:0]      req_sub,
    output logic              fp_en,
    output logic [31:0]       fp_a,
    output logic [31:0]       fp_b,
    output logic              fp_opSel,
    input  logic [31:0]       fp_q,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_q,
    output logic              idle
);

    logic [31:0]        a_arr [N];
    logic [31:0]        b_arr [N];
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     gnt_id;
    logic [IDW-1:0]     scan;
    logic               found;
    logic               issue;
    logic               stall;
    logic [LATENCY-1:0] tag_v;
    logic [IDW-1:0]     tag_id [LATENCY];
    logic [31:0]        hold_a;
    logic [31:0]        hold_b;
    logic               hold_op;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[32*gi +: 32];
        assign b_arr[gi] = req_b[32*gi +: 32];
    end

    // Scan starts just after the last grant so every requester gets a turn.
    always_comb begin
        gnt_id = '0;
        found  = 1'b0;
        scan   = ptr;
        for (int i = 0; i < N; i++) begin
            scan = (scan == IDW'(N-1)) ? '0 : scan + 1'b1;
            if (!found && req_valid[scan]) begin
                found  = 1'b1;
                gnt_id = scan;
            end
        end
    end

    assign rsp_valid = tag_v[LATENCY-1];
    assign rsp_id    = tag_id[LATENCY-1];
    assign rsp_q     = fp_q;
    assign stall     = rsp_valid & ~rsp_ready;
    assign fp_en     = ~stall;
    assign issue     = found & ~stall;
    assign req_ready = issue ? (N'(1) << gnt_id) : '0;
    assign idle      = ~|req_valid & ~|tag_v;

    // Operand lines fall back to the last issued op so they stay put across stalls.
    assign fp_a     = issue ? a_arr[gnt_id]     : hold_a;
    assign fp_b     = issue ? b_arr[gnt_id]     : hold_b;
    assign fp_opSel = issue ? ~req_sub[gnt_id]  : hold_op;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ptr     <= IDW'(N-1);
            tag_v   <= '0;
            hold_a  <= '0;
            hold_b  <= '0;
            hold_op <= 1'b1;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            if (issue) begin
                ptr     <= gnt_id;
                hold_a  <= a_arr[gnt_id];
                hold_b  <= b_arr[gnt_id];
                hold_op <= ~req_sub[gnt_id];
            end
            if (fp_en) begin
                tag_v[0]  <= issue;
                tag_id[0] <= issue ? gnt_id : '0;
                for (int i = 1; i < LATENCY; i++) begin
                    tag_v[i]  <= tag_v[i-1];
                    tag_id[i] <= tag_id[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_add_sub_arbiter.sv
// Bench for fp_add_sub_arbiter: behavioural adder stand-in, queue-based reference model,
// and a scoreboard monitor that checks every retired result against issue order.
module tb_fp_add_sub_arbiter;
    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              areset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      req_sub;
    logic              fp_en;
    logic [31:0]       fp_a;
    logic [31:0]       fp_b;
    logic              fp_opSel;
    logic [31:0]       fp_q;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_q;
    logic              idle;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_add_sub_arbiter #(.N(N), .LATENCY(LAT), .IDW(IDW)) dut (
        .clk(clk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .fp_en(fp_en), .fp_a(fp_a), .fp_b(fp_b), .fp_opSel(fp_opSel), .fp_q(fp_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q),
        .idle(idle)
    );

    // Small-integer float helpers; all operands are exact integers in [-128,128].
    function automatic int f2i(logic [31:0] f);
        int e;
        int m;
        if (f[30:23] == 8'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = 32'h0080_0000 | int'(f[22:0]);
        m = m >> (23 - e);
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] i2f(int v);
        int mag;
        int p;
        logic [31:0] r;
        r = '0;
        if (v == 0) return r;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int k = 0; k < 31; k++) if (mag[k]) p = k;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    // Stand-in for fp_add_sub: opSel=1 adds, opSel=0 subtracts, LAT enabled edges.
    logic [31:0] fa_pipe [LAT];
    always @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < LAT; i++) fa_pipe[i] <= '0;
        end else if (fp_en) begin
            fa_pipe[0] <= i2f(fp_opSel ? f2i(fp_a) + f2i(fp_b) : f2i(fp_a) - f2i(fp_b));
            for (int i = 1; i < LAT; i++) fa_pipe[i] <= fa_pipe[i-1];
        end
    end
    assign fp_q = fa_pipe[LAT-1];

    typedef struct { logic [31:0] a; logic [31:0] b; logic sub; logic [31:0] q; } op_t;
    typedef struct { int id; logic [31:0] q; int age; } fl_t;
    typedef struct { int id; logic [31:0] q; } sb_t;

    op_t ops [N][512];
    int  hd [N];
    int  tl [N];
    fl_t fl [$];
    sb_t sb [$];
    int  ptr_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic [31:0] q);
        ops[i][tl[i]] = '{a, b, sub, q};
        tl[i]++;
    endtask

    task automatic push_rand(input int i);
        int x;
        int y;
        logic s;
        x = int'($urandom_range(128, 0)) - 64;
        y = int'($urandom_range(128, 0)) - 64;
        s = 1'($urandom_range(1, 0));
        push_op(i, i2f(x), i2f(y), s, i2f(s ? x - y : x + y));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (hd[i] < tl[i]) begin
                req_valid[i]        = 1'b1;
                req_a[32*i +: 32]   = ops[i][hd[i]].a;
                req_b[32*i +: 32]   = ops[i][hd[i]].b;
                req_sub[i]          = ops[i][hd[i]].sub;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (hd[i] < tl[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One cycle: drive, compare against the model mid-cycle, advance the model.
    task automatic step(input logic rdy);
        bit out_v;
        bit stall_m;
        int g;
        int idx;
        int exp_rr;
        rsp_ready = rdy;
        drive();
        @(negedge clk);
        out_v   = (fl.size() > 0) && (fl[0].age == LAT);
        stall_m = out_v && !rdy;
        g = -1;
        if (!stall_m) begin
            for (int j = 1; j <= N; j++) begin
                idx = (ptr_m + j) % N;
                if (g < 0 && hd[idx] < tl[idx]) g = idx;
            end
        end
        exp_rr = (g >= 0) ? (1 << g) : 0;
        chk("req_ready", 64'(req_ready), 64'(exp_rr));
        chk("fp_en", 64'(fp_en), 64'(!stall_m));
        chk("rsp_valid", 64'(rsp_valid), 64'(out_v));
        chk("idle", 64'(idle), 64'(all_empty() && fl.size() == 0));
        if (out_v) begin
            chk("rsp_id", 64'(rsp_id), 64'(fl[0].id));
            chk("rsp_q", 64'(rsp_q), 64'(fl[0].q));
        end
        if (g >= 0) begin
            chk("fp_opSel", 64'(fp_opSel), 64'(!ops[g][hd[g]].sub));
            chk("fp_a", 64'(fp_a), 64'(ops[g][hd[g]].a));
            chk("fp_b", 64'(fp_b), 64'(ops[g][hd[g]].b));
        end
        if (!stall_m) begin
            if (out_v) void'(fl.pop_front());
            foreach (fl[k]) fl[k].age++;
            if (g >= 0) begin
                fl.push_back('{g, ops[g][hd[g]].q, 1});
                sb.push_back('{g, ops[g][hd[g]].q});
                ptr_m = g;
            end
        end
        @(posedge clk);
        #1;
        if (g >= 0) hd[g]++;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((fl.size() > 0 || !all_empty()) && n < 40) begin
            step(1'b1);
            n++;
        end
        checks++;
        if (fl.size() > 0 || !all_empty()) begin
            failures++;
            $display("FAIL drain_timeout_%s actual=%0d pending expected=0", name, fl.size());
        end
    endtask

    // Scoreboard monitor: every accepted result must match the oldest issued op.
    always @(negedge clk) begin
        sb_t e;
        if (!areset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=id%0d expected=none at %0t", rsp_id, $time);
            end else begin
                e = sb.pop_front();
                chk("sb_id", 64'(rsp_id), 64'(e.id));
                chk("sb_q", 64'(rsp_q), 64'(e.q));
            end
        end
    end

    initial begin
        areset    = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        ptr_m     = N - 1;
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        #12;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_idle", 64'(idle), 64'(1));
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Directed arithmetic and polarity cases.
        push_op(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
        drain("add0");
        push_op(0, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000);
        drain("sub0");
        push_op(2, 32'h40A0_0000, 32'h4040_0000, 1'b1, 32'h4000_0000);
        drain("sub2");
        push_op(1, 32'hC000_0000, 32'h4040_0000, 1'b0, 32'h3F80_0000);
        drain("add1");
        push_op(3, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000);
        push_op(3, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000);
        drain("zero3");

        // All requesters busy: round-robin 0,1,2,3,0,1,2,3 back to back.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_rand(i);
        drain("rr");

        // Backpressure with three ops in flight and a fourth request waiting.
        for (int i = 0; i < 3; i++) push_rand(i);
        for (int c = 0; c < 3; c++) step(1'b1);
        push_rand(3);
        for (int c = 0; c < 4; c++) step(1'b0);
        drain("bp");

        // Reset with two ops in flight.
        push_rand(1);
        push_rand(2);
        step(1'b1);
        step(1'b1);
        areset = 1'b1;
        fl.delete();
        sb.delete();
        ptr_m = N - 1;
        for (int i = 0; i < N; i++) hd[i] = tl[i];
        drive();
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_idle", 64'(idle), 64'(1));
        @(posedge clk);
        #1;
        areset = 1'b0;
        push_rand(3);
        push_rand(0);
        drain("after_rst");

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (tl[i] - hd[i] < 2 && $urandom_range(3, 0) == 0) push_rand(i);
            step($urandom_range(9, 0) < 7);
        end
        drain("rand");
        step(1'b1);
        chk("final_idle", 64'(idle), 64'(1));
        chk("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
